// File: rtl/uart_receive.sv
// uart_receive: 12-bit frame UART receiver (start, 8 data LSB-first,
// parity, two stops) feeding a 1-entry valid/ready holding register.
module uart_receive #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       parity,
  input  logic       serial_in,
  input  logic       rx_ready,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST =
    CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_WAIT_HIGH
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_perr;
  logic          r_ferr;
  logic          r_deliver;
  logic          r_busy;

  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_pe;
  logic          r_fe;
  logic          r_ovr;

  logic          w_rx_s;
  logic          w_sample;
  logic          w_cnt_clr;
  logic          w_par_exp;
  logic          w_room;
  logic          w_accept;

  assign w_rx_s = r_sync2;

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end

  // START samples at mid-bit; later states a full bit after that
  always_comb begin
    w_sample = 1'b0;
    unique case (r_state)
      S_START:  w_sample = (r_cnt == HALF_LAST);
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2:  w_sample = (r_cnt == FULL_LAST);
      default:  w_sample = 1'b0;
    endcase
  end

  assign w_cnt_clr = w_sample
                  || (r_state == S_IDLE)
                  || (r_state == S_WAIT_HIGH);

  assign w_par_exp = ^r_shift ^ 1'b1 ^ parity;

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_deliver <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_deliver <= 1'b0;
      r_cnt     <= w_cnt_clr ? '0 : r_cnt + CW'(1);
      unique case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_sample) begin
            if (w_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
              r_perr    <= 1'b0;
              r_ferr    <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (w_sample) begin
            r_shift   <= {w_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (w_sample) begin
            r_perr  <= (w_rx_s != w_par_exp);
            r_state <= S_STOP1;
          end
        end
        S_STOP1: begin
          if (w_sample) begin
            if (!w_rx_s) begin
              r_ferr <= 1'b1;
            end
            r_state <= S_STOP2;
          end
        end
        S_STOP2: begin
          if (w_sample) begin
            r_deliver <= 1'b1;
            r_ferr    <= r_ferr | ~w_rx_s;
            if (r_ferr || !w_rx_s) begin
              r_state <= S_WAIT_HIGH;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_accept = r_valid && rx_ready;
  assign w_room   = !r_valid || rx_ready;

  // A frame arriving into a full register is dropped, not queued
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_pe    <= 1'b0;
      r_fe    <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (r_deliver && w_room) begin
      r_data  <= r_shift;
      r_pe    <= r_perr;
      r_fe    <= r_ferr;
      r_valid <= 1'b1;
      r_ovr   <= 1'b0;
    end else if (r_deliver) begin
      r_ovr   <= 1'b1;
    end else if (w_accept) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign data_out   = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_pe;
  assign frame_err  = r_fe;
  assign overrun    = r_ovr;
  assign rx_busy    = r_busy;

endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: directed and random frames checked each cycle
// against a frame-level model of delivery time and the holding register.
module tb_uart_receive;

  localparam int CPB = 16;
  localparam int LAT = 3 + CPB / 2 + 11 * CPB;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       parity    = 1'b0;
  logic       serial_in = 1'b1;
  logic       rx_ready  = 1'b0;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  always #5 clk = ~clk;

  uart_receive #(.CLKS_PER_BIT(CPB)) dut (
    .ref_clk    (clk),
    .reset      (reset),
    .parity     (parity),
    .serial_in  (serial_in),
    .rx_ready   (rx_ready),
    .data_out   (data_out),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .rx_busy    (rx_busy)
  );

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } frame_t;

  frame_t dq[$];

  int   edge_cnt   = 0;
  int   n_vec      = 0;
  int   n_err      = 0;
  logic rst_req    = 1'b1;
  int   ready_mode = 1;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               name, act, exp, edge_cnt);
    end
  endtask

  task automatic tick(input logic line);
    @(posedge clk);
    #1;
    serial_in = line;
    reset     = rst_req;
    case (ready_mode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      2:       rx_ready = 1'($urandom_range(0, 1));
      default: rx_ready = ($urandom_range(0, 9) == 0);
    endcase
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic pbit,
                            input logic s1,
                            input logic s2,
                            output int t0);
    logic [11:0] bits;
    frame_t      f;
    bits = {s2, s1, pbit, d, 1'b0};
    t0   = 0;
    for (int b = 0; b < 12; b++) begin
      for (int k = 0; k < CPB; k++) begin
        tick(bits[b]);
        if (b == 0 && k == 0) begin
          t0    = edge_cnt + 1;
          f.cyc = t0 + LAT;
          f.d   = d;
          f.pe  = (pbit != (^d ^ 1'b1 ^ parity));
          f.fe  = !(s1 && s2);
          dq.push_back(f);
        end
      end
    end
  endtask

  logic       m_valid = 1'b0;
  logic       m_pe    = 1'b0;
  logic       m_fe    = 1'b0;
  logic       m_ovr   = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       p_rst   = 1'b1;
  logic       p_rdy   = 1'b0;
  logic       prev_v  = 1'b0;
  int         rise_cyc = -1;
  int         rise_cnt = 0;
  logic [7:0] rise_d  = 8'h00;
  logic       rise_pe = 1'b0;
  logic       rise_fe = 1'b0;

  always @(negedge clk) begin
    frame_t f;
    if (p_rst) begin
      m_valid = 1'b0;
      m_pe    = 1'b0;
      m_fe    = 1'b0;
      m_ovr   = 1'b0;
      m_data  = 8'h00;
      dq.delete();
    end else if (dq.size() > 0 && dq[0].cyc == edge_cnt) begin
      f = dq.pop_front();
      if (!m_valid || p_rdy) begin
        m_data  = f.d;
        m_pe    = f.pe;
        m_fe    = f.fe;
        m_valid = 1'b1;
        m_ovr   = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && p_rdy) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    chk("rx_valid", rx_valid, m_valid);
    chk("data_out", data_out, m_data);
    chk("parity_err", parity_err, m_pe);
    chk("frame_err", frame_err, m_fe);
    chk("overrun", overrun, m_ovr);
    if (rx_valid === 1'b1 && prev_v !== 1'b1) begin
      rise_cyc = edge_cnt;
      rise_cnt++;
      rise_d   = data_out;
      rise_pe  = parity_err;
      rise_fe  = frame_err;
    end
    prev_v = rx_valid;
    p_rst  = reset;
    p_rdy  = rx_ready;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int         t0;
    int         rc;
    int         gap;
    logic [7:0] rd;
    logic       rp;
    logic       rs1;
    logic       rs2;

    repeat (3) tick(1'b1);
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    rst_req = 1'b0;
    repeat (5) tick(1'b1);

    parity = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, t0);
    repeat (4) tick(1'b1);
    chk("t1_latency", rise_cyc - t0, 187);
    chk("t1_data", rise_d, 8'hA5);
    chk("t1_perr", rise_pe, 1'b0);
    chk("t1_ferr", rise_fe, 1'b0);

    parity = 1'b0;
    send_frame(8'h00, 1'b1, 1'b1, 1'b1, t0);
    repeat (4) tick(1'b1);
    chk("t2a_perr", rise_pe, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, t0);
    repeat (4) tick(1'b1);
    chk("t2b_data", rise_d, 8'h00);
    chk("t2b_perr", rise_pe, 1'b1);

    rc = rise_cnt;
    repeat (4) tick(1'b0);
    repeat (2) tick(1'b1);
    chk("t3_busy_start", rx_busy, 1'b1);
    repeat (20) tick(1'b1);
    chk("t3_busy_idle", rx_busy, 1'b0);
    chk("t3_no_frame", rise_cnt, rc);
    chk("t3_perr_held", parity_err, 1'b1);

    parity = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, t0);
    repeat (40) tick(1'b0);
    chk("t4_data", rise_d, 8'h5A);
    chk("t4_ferr", rise_fe, 1'b1);
    chk("t4_wait_high", rx_busy, 1'b1);
    rc = rise_cnt;
    repeat (10) tick(1'b1);
    chk("t4_idle", rx_busy, 1'b0);
    chk("t4_no_frame", rise_cnt, rc);

    ready_mode = 0;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, t0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1, t0);
    repeat (4) tick(1'b1);
    chk("t5_data", data_out, 8'h3C);
    chk("t5_valid", rx_valid, 1'b1);
    chk("t5_ovr", overrun, 1'b1);
    ready_mode = 1;
    tick(1'b1);
    ready_mode = 0;
    tick(1'b1);
    chk("t5_valid_clr", rx_valid, 1'b0);
    chk("t5_ovr_clr", overrun, 1'b0);

    ready_mode = 1;
    repeat (CPB) tick(1'b0);
    rd = 8'h77;
    for (int b = 0; b < 4; b++) begin
      repeat (CPB) tick(rd[b]);
    end
    repeat (CPB / 2) tick(rd[4]);
    rst_req = 1'b1;
    repeat (3) tick(1'b1);
    chk("t6_data", data_out, 8'h00);
    chk("t6_valid", rx_valid, 1'b0);
    chk("t6_perr", parity_err, 1'b0);
    chk("t6_ferr", frame_err, 1'b0);
    chk("t6_ovr", overrun, 1'b0);
    chk("t6_busy", rx_busy, 1'b0);
    rst_req = 1'b0;
    repeat (5) tick(1'b1);
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, t0);
    repeat (4) tick(1'b1);
    chk("t6_next_data", rise_d, 8'h81);
    chk("t6_next_perr", rise_pe, 1'b0);
    chk("t6_next_ferr", rise_fe, 1'b0);

    for (int i = 0; i < 40; i++) begin
      parity = 1'($urandom_range(0, 1));
      rd     = 8'($urandom);
      rp     = ^rd ^ 1'b1 ^ parity;
      if ($urandom_range(0, 3) == 0) rp = ~rp;
      rs1    = ($urandom_range(0, 7) != 0);
      rs2    = ($urandom_range(0, 7) != 0);
      ready_mode = $urandom_range(0, 3);
      send_frame(rd, rp, rs1, rs2, t0);
      gap = $urandom_range(0, 20) + (rs2 ? 0 : 4);
      repeat (gap) tick(1'b1);
    end

    ready_mode = 1;
    repeat (250) tick(1'b1);
    chk("drain_pending", dq.size(), 0);
    chk("drain_busy", rx_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
